store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//  Write-side counterpart of the instruction fetcher: takes a completed store request
//  (effective address plus 8/16-bit data) from execute and drives the 6502 memory write
//  beats. Covers STA/STX/STY-style byte stores, little-endian word stores and stack
//  pushes (PHA/PHP, JSR/BRK return address). Sits between execute and the memory bus.
// PARAMETERS
//  ADDR_WIDTH  16  memory address width
//  DATA_WIDTH  8   memory data width (one beat)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   synchronous, active-low reset
//  req_valid     in   1   store request present
//  req_ready     out  1   unit idle; request accepted on req_valid && req_ready at posedge
//  req_mode      in   2   0 BYTE, 1 WORD, 2 PUSH, 3 PUSH2
//  req_addr      in   16  effective address (BYTE/WORD); ignored for PUSH/PUSH2
//  req_data      in   16  [7:0] BYTE/PUSH data; [15:0] WORD/PUSH2 data
//  sp_in         in   8   current stack pointer, sampled at accept
//  mem_addr      out  16  write address
//  mem_data_out  out  8   write data
//  mem_we        out  1   write strobe
//  mem_wait      in   1   bus stall; beat completes only when mem_we=1 and mem_wait=0
//  sp_next       out  8   updated stack pointer
//  we_sp         out  1   one-cycle strobe: load sp_next into SP
//  done          out  1   one-cycle pulse: request fully written
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_we=0, we_sp=0, done=0; mem_addr=0, mem_data_out=0, sp_next=0.
//  States: IDLE -> BEAT1 -> [BEAT2] -> IDLE. All outputs registered.
//  Accept at edge N latches mode/addr/data/sp; req_ready=0 from N+1 until done.
//  BEAT1 from cycle N+1: mem_we=1, addr/data held stable while mem_wait=1.
//  Beat order: BYTE: req_addr<=data[7:0]. WORD: req_addr<=data[7:0], req_addr+1<=data[15:8].
//   PUSH: {8'h01,sp}<=data[7:0]. PUSH2: {8'h01,sp}<=data[15:8], {8'h01,sp-1}<=data[7:0].
//  Arithmetic: req_addr+1 wraps mod 2^16 (FFFF->0000); sp arithmetic mod 256 (00-1=FF).
//  Completion: cycle after last beat completes: mem_we=0, done=1, req_ready=1; back-to-back
//   request may be accepted in this cycle. BYTE with no stall: mem_we N+1, done N+2.
//  PUSH/PUSH2: sp_next=sp-1 / sp-2, we_sp=1 in the done cycle only; BYTE/WORD never pulse we_sp.
//  req_valid while busy: ignored; requester holds until req_ready.
//  Reset mid-request: IDLE at next edge, mem_we drops, no done/we_sp; completed beats not undone.
// CONFIGURATION
//  STORE_RMW_DUMMY_EN defined: extra inputs req_rmw (1) and req_old (8). BYTE with req_rmw=1
//   writes req_old then req_data[7:0] to the same address (two beats, 6502 RMW double write).
//   req_rmw is ignored for other modes.
//  Not defined: ports absent; BYTE is always a single beat.
// STRUCTURE
//  Shared defines file: STORE_MODE_BYTE/WORD/PUSH/PUSH2 encodings, STACK_PAGE 8'h01,
//   state encodings, ADDR_WIDTH/DATA_WIDTH defaults.
//  One sub-module: store_addr_gen (combinational beat address/data and sp_next select by mode/beat).
// TESTING
//  BYTE addr 0x0200 data 0x5A, no stall -> mem_we only at N+1, 0x0200<=0x5A; done N+2.
//  WORD addr 0xFFFF data 0xBEEF -> 0xFFFF<=0xEF then 0x0000<=0xBE; single done.
//  PUSH2 sp 0x00 data 0x1234 -> 0x0100<=0x12, 0x01FF<=0x34; sp_next=0xFE, we_sp one cycle.
//  WORD with mem_wait=1 for 3 cycles on beat 1 -> addr/data stable, 2 writes total, one done.
//  reset_n low during PUSH2 beat 2 -> mem_we=0 next edge, no done/we_sp, req_ready=1.
//  STORE_RMW_DUMMY_EN: BYTE rmw addr 0x0010 old 0x80 new 0x00 -> 0x80 then 0x00 written.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared encodings for the store unit: store modes, stack page, FSM states and width defaults.
// Combinational helpers only; no timing of its own.
// No flow control here; consumers own all handshaking.
package store_unit_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 8;

   localparam logic [1:0] STORE_MODE_BYTE  = 2'd0;
   localparam logic [1:0] STORE_MODE_WORD  = 2'd1;
   localparam logic [1:0] STORE_MODE_PUSH  = 2'd2;
   localparam logic [1:0] STORE_MODE_PUSH2 = 2'd3;

   // 6502 hardware stack lives in page one
   localparam logic [7:0] STACK_PAGE = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT1 = 2'd1,
      ST_BEAT2 = 2'd2
   } state_t;

   function automatic logic is_push(input logic [1:0] mode);
      return (mode == STORE_MODE_PUSH) || (mode == STORE_MODE_PUSH2);
   endfunction

endpackage

// File: rtl/store_addr_gen.sv
// Picks the address/data for the current write beat and the post-store stack pointer by mode.
// Purely combinational, zero latency.
// No backpressure; the owning FSM decides when a beat is issued or held.
module store_addr_gen
   import store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [1:0]              mode,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [2*DATA_WIDTH-1:0] data,
   input  logic [7:0]              sp,
   input  logic                    rmw,
   input  logic [DATA_WIDTH-1:0]   old,
   input  logic                    beat,
   output logic [ADDR_WIDTH-1:0]   beat_addr,
   output logic [DATA_WIDTH-1:0]   beat_data,
   output logic [7:0]              sp_upd,
   output logic                    two_beat
);

   logic [DATA_WIDTH-1:0] lo;
   logic [DATA_WIDTH-1:0] hi;
   logic [ADDR_WIDTH-1:0] stack_top;
   logic [ADDR_WIDTH-1:0] stack_nxt;

   assign lo        = data[DATA_WIDTH-1:0];
   assign hi        = data[2*DATA_WIDTH-1:DATA_WIDTH];
   // sp arithmetic stays inside the 8-bit field so 00-1 wraps to FF within page one
   assign stack_top = ADDR_WIDTH'({STACK_PAGE, sp});
   assign stack_nxt = ADDR_WIDTH'({STACK_PAGE, sp - 8'd1});

   // Beat selection: beat=0 is the first write, beat=1 the second
   always_comb begin
      beat_addr = addr;
      beat_data = lo;
      sp_upd    = sp;
      two_beat  = 1'b0;
      case (mode)
         STORE_MODE_BYTE: begin
            // RMW dummy write: old value first, then the new value to the same address
            two_beat  = rmw;
            beat_data = (rmw && !beat) ? old : lo;
         end
         STORE_MODE_WORD: begin
            two_beat  = 1'b1;
            beat_addr = beat ? addr + ADDR_WIDTH'(1) : addr;
            beat_data = beat ? hi : lo;
         end
         STORE_MODE_PUSH: begin
            beat_addr = stack_top;
            sp_upd    = sp - 8'd1;
         end
         STORE_MODE_PUSH2: begin
            // high byte goes on first so the pair reads back little-endian from sp+1
            two_beat  = 1'b1;
            beat_addr = beat ? stack_nxt : stack_top;
            beat_data = beat ? lo : hi;
            sp_upd    = sp - 8'd2;
         end
         default: begin
            two_beat = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns one execute-stage store request into one or two 6502 memory write beats.
// Latency: first beat the cycle after accept, done the cycle after the last beat completes.
// Backpressure: req_ready low while busy; each beat holds while mem_wait is high.
// Optional STORE_RMW_DUMMY_EN adds req_rmw/req_old for the RMW double-write on BYTE stores.
module store_unit
   import store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_mode,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_data,
   input  logic [7:0]              sp_in,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_data_out,
   output logic                    mem_we,
   input  logic                    mem_wait,
   output logic [7:0]              sp_next,
   output logic                    we_sp,
   output logic                    done
`ifdef STORE_RMW_DUMMY_EN
   ,
   input  logic                    req_rmw,
   input  logic [DATA_WIDTH-1:0]   req_old
`endif
);

   state_t                  state;
   logic [1:0]              mode_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2*DATA_WIDTH-1:0] data_q;
   logic [7:0]              sp_q;

   logic                    idle;
   logic [1:0]              g_mode;
   logic [ADDR_WIDTH-1:0]   g_addr;
   logic [2*DATA_WIDTH-1:0] g_data;
   logic [7:0]              g_sp;
   logic                    g_rmw;
   logic [DATA_WIDTH-1:0]   g_old;
   logic [ADDR_WIDTH-1:0]   beat_addr;
   logic [DATA_WIDTH-1:0]   beat_data;
   logic [7:0]              sp_upd;
   logic                    two_beat;

   // In IDLE the generator looks at the incoming request so beat 1 can be registered at accept;
   // once busy it looks at the latched request to produce beat 2 and the final sp.
   assign idle   = (state == ST_IDLE);
   assign g_mode = idle ? req_mode : mode_q;
   assign g_addr = idle ? req_addr : addr_q;
   assign g_data = idle ? req_data : data_q;
   assign g_sp   = idle ? sp_in    : sp_q;

`ifdef STORE_RMW_DUMMY_EN
   logic                  rmw_q;
   logic [DATA_WIDTH-1:0] old_q;

   assign g_rmw = idle ? req_rmw : rmw_q;
   assign g_old = idle ? req_old : old_q;

   // Latch the RMW controls alongside the rest of the request
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rmw_q <= 1'b0;
         old_q <= '0;
      end else if (idle && req_valid) begin
         rmw_q <= req_rmw;
         old_q <= req_old;
      end
   end
`else
   assign g_rmw = 1'b0;
   assign g_old = '0;
`endif

   store_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_addr_gen (
      .mode      (g_mode),
      .addr      (g_addr),
      .data      (g_data),
      .sp        (g_sp),
      .rmw       (g_rmw),
      .old       (g_old),
      .beat      (state == ST_BEAT1),
      .beat_addr (beat_addr),
      .beat_data (beat_data),
      .sp_upd    (sp_upd),
      .two_beat  (two_beat)
   );

   // Control FSM with registered outputs: accept, issue beats, pulse done/we_sp on completion
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         req_ready    <= 1'b1;
         mem_we       <= 1'b0;
         we_sp        <= 1'b0;
         done         <= 1'b0;
         mem_addr     <= '0;
         mem_data_out <= '0;
         sp_next      <= '0;
         mode_q       <= STORE_MODE_BYTE;
         addr_q       <= '0;
         data_q       <= '0;
         sp_q         <= '0;
      end else begin
         done  <= 1'b0;
         we_sp <= 1'b0;
         if (state == ST_IDLE) begin
            if (req_valid) begin
               mode_q       <= req_mode;
               addr_q       <= req_addr;
               data_q       <= req_data;
               sp_q         <= sp_in;
               state        <= ST_BEAT1;
               req_ready    <= 1'b0;
               mem_we       <= 1'b1;
               mem_addr     <= beat_addr;
               mem_data_out <= beat_data;
            end
         end else if (!mem_wait) begin
            if (state == ST_BEAT1 && two_beat) begin
               state        <= ST_BEAT2;
               mem_addr     <= beat_addr;
               mem_data_out <= beat_data;
            end else begin
               // last beat taken by the bus: done cycle doubles as the next accept slot
               state     <= ST_IDLE;
               mem_we    <= 1'b0;
               req_ready <= 1'b1;
               done      <= 1'b1;
               if (is_push(mode_q)) begin
                  we_sp   <= 1'b1;
                  sp_next <= sp_upd;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: vector table of single requests plus reset/RMW sequences.
module tb_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_mode;
   logic [15:0] req_addr;
   logic [15:0] req_data;
   logic [7:0]  sp_in;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out;
   logic        mem_we;
   logic        mem_wait;
   logic [7:0]  sp_next;
   logic        we_sp;
   logic        done;
`ifdef STORE_RMW_DUMMY_EN
   logic        req_rmw;
   logic [7:0]  req_old;
`endif

   int n_vec = 0;
   int n_err = 0;

   store_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_mode     (req_mode),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .sp_in        (sp_in),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_we       (mem_we),
      .mem_wait     (mem_wait),
      .sp_next      (sp_next),
      .we_sp        (we_sp),
      .done         (done)
`ifdef STORE_RMW_DUMMY_EN
      ,
      .req_rmw      (req_rmw),
      .req_old      (req_old)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] addr;
      logic [15:0] data;
      logic [7:0]  sp;
      int          stall;
      int          nbeats;
      logic [15:0] a0;
      logic [7:0]  d0;
      logic [15:0] a1;
      logic [7:0]  d1;
      int          wsp;
      logic [7:0]  spn;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request at the current negedge and observe until done (bounded).
   // Returns at the negedge of the done cycle so the next call tests back-to-back accept.
   task automatic run_req(input logic [1:0] mode, input logic [15:0] addr, input logic [15:0] data,
                          input logic [7:0] sp, input logic rmw, input logic [7:0] old, input int stall,
                          output int nb, output logic [15:0] a0, output logic [7:0] d0,
                          output logic [15:0] a1, output logic [7:0] d1, output int done_cyc,
                          output int done_cnt, output int wsp_cnt, output logic [7:0] spn,
                          output int bad);
      int          stall_left;
      logic [15:0] sa;
      logic [7:0]  sd;
      nb = 0; a0 = '0; d0 = '0; a1 = '0; d1 = '0;
      done_cyc = -1; done_cnt = 0; wsp_cnt = 0; spn = '0; bad = 0;
      stall_left = stall; sa = '0; sd = '0;
      req_valid = 1'b1;
      req_mode  = mode;
      req_addr  = addr;
      req_data  = data;
      sp_in     = sp;
`ifdef STORE_RMW_DUMMY_EN
      req_rmw   = rmw;
      req_old   = old;
`else
      if (rmw || old != 8'h00) $display("note: rmw fields ignored in this build");
`endif
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 16'h5555;
      req_data  = 16'hAAAA;
      sp_in     = 8'h77;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (mem_we) begin
            if (req_ready) bad++;
            if (nb == 0 && stall_left > 0) begin
               if (stall_left == stall) begin
                  sa = mem_addr;
                  sd = mem_data_out;
               end else if (mem_addr != sa || mem_data_out != sd) begin
                  bad++;
               end
               mem_wait = 1'b1;
               stall_left--;
            end else begin
               if (nb == 0 && stall > 0 && (mem_addr != sa || mem_data_out != sd)) bad++;
               mem_wait = 1'b0;
               if (nb == 0) begin
                  a0 = mem_addr; d0 = mem_data_out;
               end else begin
                  a1 = mem_addr; d1 = mem_data_out;
               end
               nb++;
            end
         end else begin
            mem_wait = 1'b0;
         end
         if (we_sp) begin
            wsp_cnt++;
            spn = sp_next;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (mem_we || !req_ready) bad++;
            break;
         end
         @(negedge clk);
      end
      mem_wait = 1'b0;
   endtask

   initial begin
      int          nb, done_cyc, done_cnt, wsp_cnt, bad;
      logic [15:0] a0, a1;
      logic [7:0]  d0, d1, spn;

      //        mode   addr      data      sp     st nb a0        d0     a1        d1     wsp spn
      vt[0] = '{2'd0, 16'h0200, 16'h005A, 8'h33, 0, 1, 16'h0200, 8'h5A, 16'h0000, 8'h00, 0, 8'h00};
      vt[1] = '{2'd1, 16'hFFFF, 16'hBEEF, 8'h10, 0, 2, 16'hFFFF, 8'hEF, 16'h0000, 8'hBE, 0, 8'h00};
      vt[2] = '{2'd3, 16'h3000, 16'h1234, 8'h00, 0, 2, 16'h0100, 8'h12, 16'h01FF, 8'h34, 1, 8'hFE};
      vt[3] = '{2'd2, 16'h1234, 16'h00A7, 8'hFD, 0, 1, 16'h01FD, 8'hA7, 16'h0000, 8'h00, 1, 8'hFC};
      vt[4] = '{2'd1, 16'h1000, 16'hABCD, 8'h20, 3, 2, 16'h1000, 8'hCD, 16'h1001, 8'hAB, 0, 8'h00};
      vt[5] = '{2'd2, 16'h0000, 16'h0042, 8'h00, 0, 1, 16'h0100, 8'h42, 16'h0000, 8'h00, 1, 8'hFF};
      vt[6] = '{2'd0, 16'hFFFF, 16'h1100, 8'h80, 2, 1, 16'hFFFF, 8'h00, 16'h0000, 8'h00, 0, 8'h00};
      vt[7] = '{2'd3, 16'h0000, 16'hC0DE, 8'h01, 0, 2, 16'h0101, 8'hC0, 16'h0100, 8'hDE, 1, 8'hFF};

      reset_n = 1'b0; req_valid = 1'b0; req_mode = 2'd0; req_addr = '0; req_data = '0;
      sp_in = '0; mem_wait = 1'b0;
`ifdef STORE_RMW_DUMMY_EN
      req_rmw = 1'b0; req_old = '0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_we_sp",     32'(we_sp),     32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_data",  32'(mem_data_out), 32'd0);
      chk("rst_sp_next",   32'(sp_next),   32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_req(vt[i].mode, vt[i].addr, vt[i].data, vt[i].sp, 1'b0, 8'h00, vt[i].stall,
                 nb, a0, d0, a1, d1, done_cyc, done_cnt, wsp_cnt, spn, bad);
         chk($sformatf("v%0d_beats", i),    32'(nb),       32'(vt[i].nbeats));
         chk($sformatf("v%0d_addr0", i),    32'(a0),       32'(vt[i].a0));
         chk($sformatf("v%0d_data0", i),    32'(d0),       32'(vt[i].d0));
         if (vt[i].nbeats == 2) begin
            chk($sformatf("v%0d_addr1", i), 32'(a1),       32'(vt[i].a1));
            chk($sformatf("v%0d_data1", i), 32'(d1),       32'(vt[i].d1));
         end
         chk($sformatf("v%0d_done_cyc", i), 32'(done_cyc), 32'(1 + vt[i].stall + vt[i].nbeats));
         chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
         chk($sformatf("v%0d_we_sp_cnt", i), 32'(wsp_cnt), 32'(vt[i].wsp));
         if (vt[i].wsp == 1)
            chk($sformatf("v%0d_sp_next", i), 32'(spn),    32'(vt[i].spn));
         chk($sformatf("v%0d_protocol", i), 32'(bad),      32'd0);
      end

      // Reset asserted while PUSH2 beat 2 is on the bus
      req_valid = 1'b1; req_mode = 2'd3; req_data = 16'h5566; sp_in = 8'h40; req_addr = 16'h0000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_beat1_addr", 32'(mem_addr), 32'h0140);
      @(negedge clk);
      chk("rstmid_beat2_we",   32'(mem_we),   32'd1);
      chk("rstmid_beat2_addr", 32'(mem_addr), 32'h013F);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rstmid_we",    32'(mem_we),    32'd0);
      chk("rstmid_done",  32'(done),      32'd0);
      chk("rstmid_we_sp", 32'(we_sp),     32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rstmid_done_after",  32'(done),  32'd0);
      chk("rstmid_we_sp_after", 32'(we_sp), 32'd0);
      chk("rstmid_we_after",    32'(mem_we), 32'd0);

`ifdef STORE_RMW_DUMMY_EN
      // RMW double write: old value then new value to the same address
      run_req(2'd0, 16'h0010, 16'h0000, 8'h00, 1'b1, 8'h80, 0,
              nb, a0, d0, a1, d1, done_cyc, done_cnt, wsp_cnt, spn, bad);
      chk("rmw_beats",    32'(nb),       32'd2);
      chk("rmw_addr0",    32'(a0),       32'h0010);
      chk("rmw_data0",    32'(d0),       32'h80);
      chk("rmw_addr1",    32'(a1),       32'h0010);
      chk("rmw_data1",    32'(d1),       32'h00);
      chk("rmw_done_cyc", 32'(done_cyc), 32'd3);
      chk("rmw_we_sp",    32'(wsp_cnt),  32'd0);
      // rmw flag has no effect on a push
      run_req(2'd2, 16'h0000, 16'h0099, 8'h50, 1'b1, 8'h11, 0,
              nb, a0, d0, a1, d1, done_cyc, done_cnt, wsp_cnt, spn, bad);
      chk("rmw_push_beats", 32'(nb), 32'd1);
      chk("rmw_push_addr",  32'(a0), 32'h0150);
      chk("rmw_push_data",  32'(d0), 32'h99);
      chk("rmw_push_sp",    32'(spn), 32'h4F);
      req_rmw = 1'b0;
`endif

      // No stray pulses once idle
      @(negedge clk);
      chk("idle_done",  32'(done),   32'd0);
      chk("idle_we_sp", 32'(we_sp),  32'd0);
      chk("idle_we",    32'(mem_we), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
